// File: rtl/shift_deserializer_pkg.sv
// Shared state encodings and defaults for the serial-to-parallel receiver.
package shift_deserializer_pkg;

  localparam int unsigned DESER_DEFAULT_WIDTH = 16;

  typedef enum logic {
    DESER_IDLE  = 1'b0,
    DESER_ACCUM = 1'b1
  } deser_state_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/shift_deserializer_out_buffer.sv
// One-entry valid/ready holding register for completed words, with overrun pulse.
module shift_deserializer_out_buffer
  import shift_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = DESER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             overrun_o
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BUF_EMPTY;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      overrun_q <= overrun_d;
    end
  end

  // A full buffer accepts a new word only if the old one drains on the same edge.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    overrun_d = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (load_i) begin
          word_d  = word_i;
          state_d = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (ready_i) begin
          state_d = BUF_EMPTY;
        end
        if (load_i) begin
          if (ready_i) begin
            word_d  = word_i;
            state_d = BUF_FULL;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  assign word_o    = word_q;
  assign valid_o   = (state_q == BUF_FULL);
  assign overrun_o = overrun_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: shifts sampled bits into a WIDTH-bit word and hands
// completed words to a one-entry valid/ready output buffer.
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DESER_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     serialIn,
  input  logic                     serialValid,
  input  logic                     frameStart,
  output logic [WIDTH-1:0]         wordOut,
  output logic                     wordValid,
  input  logic                     wordReady,
  output logic                     overrun,
  output logic [$clog2(WIDTH):0]   bitCount
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  deser_state_e     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_base_c;
  logic [WIDTH-1:0] shifted_c;
  logic [CW-1:0]    cnt_base_c;
  logic             load_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DESER_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // frameStart restarts the word before this cycle's bit is sampled.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    load_c     = 1'b0;
    acc_base_c = frameStart ? '0 : acc_q;
    cnt_base_c = (frameStart || state_q == DESER_IDLE) ? '0 : cnt_q;
    shifted_c  = MSB_FIRST ? {acc_base_c[WIDTH-2:0], serialIn}
                           : {serialIn, acc_base_c[WIDTH-1:1]};
    if (frameStart && !serialValid) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = DESER_IDLE;
    end else if (serialValid) begin
      acc_d = shifted_c;
      if (cnt_base_c == CW'(WIDTH - 1)) begin
        load_c  = 1'b1;
        cnt_d   = '0;
        state_d = DESER_IDLE;
      end else begin
        cnt_d   = cnt_base_c + CW'(1);
        state_d = DESER_ACCUM;
      end
    end
  end

  shift_deserializer_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_c),
    .word_i    (shifted_c),
    .ready_i   (wordReady),
    .word_o    (wordOut),
    .valid_o   (wordValid),
    .overrun_o (overrun)
  );

  assign bitCount = cnt_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: one MSB-first and one LSB-first instance
// share the same serial stream, so each word checks both shift directions.
module tb_shift_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial_in, serial_valid, frame_start, word_ready;
  logic [15:0] word_m, word_l;
  logic        valid_m, valid_l, ovr_m, ovr_l;
  logic [4:0]  cnt_m, cnt_l;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(16), .MSB_FIRST(1'b1)) d_msb (
    .clk(clk), .rst_n(rst_n), .serialIn(serial_in), .serialValid(serial_valid),
    .frameStart(frame_start), .wordOut(word_m), .wordValid(valid_m),
    .wordReady(word_ready), .overrun(ovr_m), .bitCount(cnt_m)
  );

  shift_deserializer #(.WIDTH(16), .MSB_FIRST(1'b0)) d_lsb (
    .clk(clk), .rst_n(rst_n), .serialIn(serial_in), .serialValid(serial_valid),
    .frameStart(frame_start), .wordOut(word_l), .wordValid(valid_l),
    .wordReady(word_ready), .overrun(ovr_l), .bitCount(cnt_l)
  );

  typedef struct {
    logic [15:0] stream;   // bit 15 is sent first
    int          gap;      // idle cycle before every gap-th bit (0 = none)
    logic [15:0] exp_msb;
    logic [15:0] exp_lsb;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    serial_valid = 1'b0;
    frame_start = 1'b0;
    serial_in = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Sends nbits of stream starting at bit 15; optional idle gaps check bitCount holds.
  task automatic send_bits(input logic [15:0] stream, input int nbits, input int gap,
                           input bit ready_last);
    for (int k = 0; k < nbits; k++) begin
      if (gap != 0 && k != 0 && (k % gap) == 0) begin
        serial_valid = 1'b0;
        tick();
        chk("gap_hold_cnt", 32'(cnt_m), 32'(k));
      end
      if (ready_last && k == nbits - 1) word_ready = 1'b1;
      serial_in    = stream[15-k];
      serial_valid = 1'b1;
      tick();
    end
    serial_valid = 1'b0;
  endtask

  initial begin
    word_ready = 1'b1;
    do_reset();
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_word", 32'(word_m), 32'd0);
    chk("rst_cnt", 32'(cnt_m), 32'd0);
    chk("rst_ovr", 32'(ovr_m), 32'd0);

    vecs[0] = '{stream: 16'hA5C3, gap: 0, exp_msb: 16'hA5C3, exp_lsb: 16'hC3A5};
    vecs[1] = '{stream: 16'h2C48, gap: 3, exp_msb: 16'h2C48, exp_lsb: 16'h1234};
    vecs[2] = '{stream: 16'h00FF, gap: 0, exp_msb: 16'h00FF, exp_lsb: 16'hFF00};
    vecs[3] = '{stream: 16'h8001, gap: 2, exp_msb: 16'h8001, exp_lsb: 16'h8001};

    // Single words with consumer always ready: valid for exactly one cycle.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      word_ready = 1'b1;
      send_bits(vecs[v].stream, 16, vecs[v].gap, 1'b0);
      chk("vec_valid", 32'(valid_m), 32'd1);
      chk("vec_word_msb", 32'(word_m), 32'(vecs[v].exp_msb));
      chk("vec_word_lsb", 32'(word_l), 32'(vecs[v].exp_lsb));
      chk("vec_cnt_wrap", 32'(cnt_m), 32'd0);
      chk("vec_ovr", 32'(ovr_m | ovr_l), 32'd0);
      tick();
      chk("vec_valid_drop", 32'(valid_m), 32'd0);
    end

    // Overrun: buffer full and not draining drops the second word.
    do_reset();
    word_ready = 1'b0;
    send_bits(16'hFFFF, 16, 0, 1'b0);
    chk("ovr_first_word", 32'(word_m), 32'hFFFF);
    send_bits(16'h8000, 16, 0, 1'b0);
    chk("ovr_pulse", 32'(ovr_m), 32'd1);
    chk("ovr_word_kept", 32'(word_m), 32'hFFFF);
    chk("ovr_valid", 32'(valid_m), 32'd1);
    tick();
    chk("ovr_one_cycle", 32'(ovr_m), 32'd0);
    word_ready = 1'b1;
    tick();
    chk("ovr_drain", 32'(valid_m), 32'd0);

    // Ready on the completing cycle replaces the held word without overrun.
    do_reset();
    word_ready = 1'b0;
    send_bits(16'hBEEF, 16, 0, 1'b0);
    send_bits(16'h0F0F, 15, 0, 1'b0);
    chk("swap_held", 32'(word_m), 32'hBEEF);
    send_bits(16'hF000, 1, 0, 1'b1);
    chk("swap_word", 32'(word_m), 32'h0F0F);
    chk("swap_valid", 32'(valid_m), 32'd1);
    chk("swap_ovr", 32'(ovr_m), 32'd0);

    // frameStart with a valid bit restarts the word at bitCount=1.
    do_reset();
    word_ready = 1'b1;
    send_bits(16'hFFFF, 7, 0, 1'b0);
    chk("fs_pre_cnt", 32'(cnt_m), 32'd7);
    frame_start = 1'b1;
    serial_in = 1'b1;
    serial_valid = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fs_cnt", 32'(cnt_m), 32'd1);
    send_bits(16'h0000, 15, 0, 1'b0);
    chk("fs_word_msb", 32'(word_m), 32'h8000);
    chk("fs_word_lsb", 32'(word_l), 32'h0001);

    // frameStart without a valid bit returns to idle.
    send_bits(16'hFFFF, 5, 0, 1'b0);
    frame_start = 1'b1;
    serial_valid = 1'b0;
    tick();
    frame_start = 1'b0;
    chk("fs_idle_cnt", 32'(cnt_m), 32'd0);

    // Reset mid-word with a full buffer clears everything.
    do_reset();
    word_ready = 1'b0;
    send_bits(16'h1234, 16, 0, 1'b0);
    send_bits(16'hFFFF, 10, 0, 1'b0);
    chk("mid_cnt", 32'(cnt_m), 32'd10);
    do_reset();
    chk("mid_rst_valid", 32'(valid_m), 32'd0);
    chk("mid_rst_word", 32'(word_m), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_m), 32'd0);
    word_ready = 1'b1;
    send_bits(16'hA5C3, 16, 0, 1'b0);
    chk("mid_clean_word", 32'(word_m), 32'hA5C3);
    chk("mid_clean_valid", 32'(valid_m), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
